// File: rtl/tc_vc_mapper.sv
// Traffic-class to virtual-channel mapper. It sits in front of the VC0/VC1 FIFOs,
// keeps one word in a hold register and issues registered writes under almost-full back-pressure.
module tc_vc_mapper #(
  parameter int          BW16   = 16,
  parameter int          TC_LSB = 8,
  parameter logic [7:0]  TC_MAP = 8'hF0,
  parameter int          CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              in_valid,
  input  logic [BW16-1:0]   in_data,
  output logic              in_ready,
  input  logic              VC0_almost_full,
  input  logic              VC1_almost_full,
  output logic              VC0_wr,
  output logic [BW16-1:0]   VC0_data,
  output logic              VC1_wr,
  output logic [BW16-1:0]   VC1_data,
  output logic [CNT_W-1:0]  vc0_count,
  output logic [CNT_W-1:0]  vc1_count,
  output logic              stalled
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [BW16-1:0]    hold_data_q, hold_data_d;
  logic               hold_dest_q, hold_dest_d;
  logic               vc0_wr_q, vc0_wr_d;
  logic               vc1_wr_q, vc1_wr_d;
  logic [BW16-1:0]    vc0_data_q, vc0_data_d;
  logic [BW16-1:0]    vc1_data_q, vc1_data_d;
  logic [CNT_W-1:0]   vc0_cnt_q, vc0_cnt_d;
  logic [CNT_W-1:0]   vc1_cnt_q, vc1_cnt_d;
  logic               stalled_q;

  logic               hold_valid_s;
  logic               blocked_s;
  logic               issue_s;
  logic               accept_s;
  logic               in_dest_s;
  state_t             load_state_s;

  function automatic logic map_dest(input logic [2:0] tc);
    return TC_MAP[tc];
  endfunction

  function automatic logic dest_full(input logic dest, input logic af0, input logic af1);
    return dest ? af1 : af0;
  endfunction

  assign hold_valid_s = (state_q != ST_EMPTY);
  assign blocked_s    = hold_valid_s & dest_full(hold_dest_q, VC0_almost_full, VC1_almost_full);
  assign issue_s      = hold_valid_s & ~blocked_s;
  assign in_ready     = ~hold_valid_s | ~blocked_s;
  assign accept_s     = in_valid & in_ready;
  assign in_dest_s    = map_dest(in_data[TC_LSB +: 3]);
  assign load_state_s = dest_full(in_dest_s, VC0_almost_full, VC1_almost_full) ? ST_STALL : ST_HOLD;

  // Next-state, hold-register and FIFO-write decode.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_dest_d = hold_dest_q;
    vc0_wr_d    = 1'b0;
    vc1_wr_d    = 1'b0;
    vc0_data_d  = vc0_data_q;
    vc1_data_d  = vc1_data_q;
    vc0_cnt_d   = vc0_cnt_q;
    vc1_cnt_d   = vc1_cnt_q;

    if (issue_s) begin
      if (hold_dest_q) begin
        vc1_wr_d   = 1'b1;
        vc1_data_d = hold_data_q;
        vc1_cnt_d  = vc1_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        vc0_wr_d   = 1'b1;
        vc0_data_d = hold_data_q;
        vc0_cnt_d  = vc0_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      vc0_wr_d = 1'b0;
      vc1_wr_d = 1'b0;
    end

    if (accept_s) begin
      hold_data_d = in_data;
      hold_dest_d = in_dest_s;
    end else begin
      hold_data_d = hold_data_q;
      hold_dest_d = hold_dest_q;
    end

    // A word that stays put was not issued, so its destination is almost full.
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) state_d = load_state_s;
        else          state_d = ST_EMPTY;
      end
      ST_HOLD, ST_STALL: begin
        if (accept_s)     state_d = load_state_s;
        else if (issue_s) state_d = ST_EMPTY;
        else              state_d = ST_STALL;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State, hold register, registered FIFO writes, counters and stall flag.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= ST_EMPTY;
      hold_data_q <= {BW16{1'b0}};
      hold_dest_q <= 1'b0;
      vc0_wr_q    <= 1'b0;
      vc1_wr_q    <= 1'b0;
      vc0_data_q  <= {BW16{1'b0}};
      vc1_data_q  <= {BW16{1'b0}};
      vc0_cnt_q   <= {CNT_W{1'b0}};
      vc1_cnt_q   <= {CNT_W{1'b0}};
      stalled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_dest_q <= hold_dest_d;
      vc0_wr_q    <= vc0_wr_d;
      vc1_wr_q    <= vc1_wr_d;
      vc0_data_q  <= vc0_data_d;
      vc1_data_q  <= vc1_data_d;
      vc0_cnt_q   <= vc0_cnt_d;
      vc1_cnt_q   <= vc1_cnt_d;
      stalled_q   <= (state_d == ST_STALL);
    end
  end

  assign VC0_wr    = vc0_wr_q;
  assign VC1_wr    = vc1_wr_q;
  assign VC0_data  = vc0_data_q;
  assign VC1_data  = vc1_data_q;
  assign vc0_count = vc0_cnt_q;
  assign vc1_count = vc1_cnt_q;
  assign stalled   = stalled_q;

endmodule
